// File: rtl/counter_sequencer.sv
`timescale 1ns/1ps
// Command-driven sequencer for a WIDTH-bit up-counter: CLEAR/LOAD/RUN/STOP over valid/ready,
// RUN advances the count N steps at one step per DIV clocks and reports done/aborted.
module counter_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk_12m,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             wrap
);

  localparam int            PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_RUN   = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] count_nx;
  logic [WIDTH-1:0] remaining, remaining_nx;
  logic [PW-1:0]    ps, ps_nx;
  logic             wrap_nx, aborted_nx;
  logic             accept;
  logic [WIDTH:0]   stepped;

  // Modulo increment; the extra MSB is the carry that flags an all-ones -> zero step.
  function automatic logic [WIDTH:0] step_count(input logic [WIDTH-1:0] v);
    return {1'b0, v} + {{WIDTH{1'b0}}, 1'b1};
  endfunction

  // Only STOP may enter while running; everything else stalls until DONE/IDLE.
  assign cmd_ready = (state != S_RUN) || (cmd_op == OP_STOP);
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    state_nx     = state;
    count_nx     = count;
    remaining_nx = remaining;
    ps_nx        = ps;
    wrap_nx      = 1'b0;
    aborted_nx   = 1'b0;
    stepped      = step_count(count);

    case (state)
      S_RUN: begin
        if (ps == PS_LAST) begin
          ps_nx        = '0;
          count_nx     = stepped[WIDTH-1:0];
          wrap_nx      = stepped[WIDTH];
          remaining_nx = remaining - 1'b1;
          if (remaining == WIDTH'(1)) state_nx = S_DONE;
        end else begin
          ps_nx = ps + 1'b1;
        end
        // An accepted command here is always STOP; the step above still lands.
        if (accept) begin
          state_nx     = S_IDLE;
          remaining_nx = '0;
          ps_nx        = '0;
          aborted_nx   = 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        if (accept) begin
          case (cmd_op)
            OP_CLEAR: count_nx = '0;
            OP_LOAD:  count_nx = cmd_arg;
            OP_RUN: begin
              if (cmd_arg != '0) begin
                remaining_nx = cmd_arg;
                ps_nx        = '0;
                state_nx     = S_RUN;
              end else begin
                state_nx = S_DONE;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk_12m) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      remaining <= '0;
      ps        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      remaining <= remaining_nx;
      ps        <= ps_nx;
      busy      <= (state_nx == S_RUN);
      done      <= (state_nx == S_DONE);
      aborted   <= aborted_nx;
      wrap      <= wrap_nx;
    end
  end

endmodule
